// File: rtl/ym_bus_sched.sv
// rtl/ym_bus_sched.sv - CPU/player arbiter and two-phase BDIR/BC bus sequencer for the PSG
module ym_bus_sched #(
    parameter int STB_CYC = 2
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       CPU_REQ,
    input  logic       CPU_WE,
    input  logic [3:0] CPU_ADDR,
    input  logic [7:0] CPU_WDATA,
    output logic       CPU_ACK,
    output logic [7:0] CPU_RDATA,
    input  logic       PLY_VALID,
    input  logic [3:0] PLY_ADDR,
    input  logic [7:0] PLY_DATA,
    output logic       PLY_READY,
    input  logic       PSG_RST,
    output logic       PSG_BDIR,
    output logic       PSG_BC,
    output logic       PSG_CS,
    output logic [7:0] PSG_DI,
    input  logic [7:0] PSG_DO,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        S_IDLE, S_ASU, S_AST, S_AHD, S_DSU, S_DST, S_DHD, S_RD
    } state_t;

    localparam logic [3:0] STB_LOAD = 4'(STB_CYC - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] r_addr;
    logic [7:0] r_data;
    logic       r_we;
    logic       r_own_cpu;
    logic       r_last_cpu;
    logic       r_cache_vld;
    logic [3:0] r_cache_addr;
    logic       r_ack;
    logic [7:0] r_rdata;
    logic       r_bdir;
    logic       r_bc;
    logic       r_cs;
    logic [7:0] r_di;

    logic       w_gnt_cpu;
    logic       w_gnt_ply;
    logic [3:0] w_gnt_addr;
    logic [7:0] w_gnt_data;
    logic       w_gnt_we;
    logic       w_hit;
    logic [3:0] w_cur_addr;
    logic [7:0] w_cur_data;
    logic       w_bdir_nxt;
    logic       w_bc_nxt;
    logic       w_cs_nxt;
    logic [7:0] w_di_nxt;

    // Round-robin: on a tie the requester that did not win last time goes first.
    assign w_gnt_cpu  = (r_state == S_IDLE) && CPU_REQ && (!PLY_VALID || !r_last_cpu);
    assign w_gnt_ply  = (r_state == S_IDLE) && PLY_VALID && !w_gnt_cpu;
    assign w_gnt_addr = w_gnt_cpu ? CPU_ADDR : PLY_ADDR;
    assign w_gnt_data = w_gnt_cpu ? CPU_WDATA : PLY_DATA;
    assign w_gnt_we   = w_gnt_cpu ? CPU_WE : 1'b1;
    assign w_hit      = r_cache_vld && (r_cache_addr == w_gnt_addr);
    // Payload for the next bus value: straight from the requester in the grant cycle.
    assign w_cur_addr = (r_state == S_IDLE) ? w_gnt_addr : r_addr;
    assign w_cur_data = (r_state == S_IDLE) ? w_gnt_data : r_data;

    assign PLY_READY = w_gnt_ply;
    assign CPU_ACK   = r_ack;
    assign CPU_RDATA = r_rdata;
    assign PSG_BDIR  = r_bdir;
    assign PSG_BC    = r_bc;
    assign PSG_CS    = r_cs;
    assign PSG_DI    = r_di;
    assign BUSY      = (r_state != S_IDLE);

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state: skip the address phase on a cache hit; strobes end when the counter hits 0.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_gnt_cpu || w_gnt_ply)
                        w_state_nxt = w_hit ? (w_gnt_we ? S_DSU : S_RD) : S_ASU;
            S_ASU:  w_state_nxt = S_AST;
            S_AST:  if (r_cnt == 4'd0) w_state_nxt = S_AHD;
            S_AHD:  w_state_nxt = r_we ? S_DSU : S_RD;
            S_DSU:  w_state_nxt = S_DST;
            S_DST:  if (r_cnt == 4'd0) w_state_nxt = S_DHD;
            S_DHD:  w_state_nxt = S_IDLE;
            S_RD:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bus values for the upcoming state; registered below so the PSG pins are glitch-free.
    always_comb begin
        w_bdir_nxt = (w_state_nxt == S_AST) || (w_state_nxt == S_DST);
        w_bc_nxt   = (w_state_nxt == S_ASU) || (w_state_nxt == S_AST) ||
                     (w_state_nxt == S_AHD) || (w_state_nxt == S_RD);
        w_cs_nxt   = (w_state_nxt != S_IDLE);
        w_di_nxt   = r_di;
        if (w_state_nxt == S_ASU && r_state != S_ASU) w_di_nxt = {4'd0, w_cur_addr};
        if (w_state_nxt == S_DSU && r_state != S_DSU) w_di_nxt = w_cur_data;
    end

    // Datapath: strobe counter, grant capture, address cache, completion and bus outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt        <= 4'd0;
            r_addr       <= 4'd0;
            r_data       <= 8'd0;
            r_we         <= 1'b0;
            r_own_cpu    <= 1'b0;
            r_last_cpu   <= 1'b0;
            r_cache_vld  <= 1'b0;
            r_cache_addr <= 4'd0;
            r_ack        <= 1'b0;
            r_rdata      <= 8'd0;
            r_bdir       <= 1'b0;
            r_bc         <= 1'b0;
            r_cs         <= 1'b0;
            r_di         <= 8'd0;
        end else begin
            if ((w_state_nxt == S_AST && r_state != S_AST) ||
                (w_state_nxt == S_DST && r_state != S_DST))
                r_cnt <= STB_LOAD;
            else if (r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;

            if (w_gnt_cpu || w_gnt_ply) begin
                r_addr     <= w_gnt_addr;
                r_data     <= w_gnt_data;
                r_we       <= w_gnt_we;
                r_own_cpu  <= w_gnt_cpu;
                r_last_cpu <= w_gnt_cpu;
            end

            // PSG reset wins over a cache fill in the same cycle.
            if (PSG_RST) begin
                r_cache_vld <= 1'b0;
            end else if (r_state == S_AHD) begin
                r_cache_vld  <= 1'b1;
                r_cache_addr <= r_addr;
            end

            r_ack <= ((r_state == S_DHD) || (r_state == S_RD)) && r_own_cpu;
            if (r_state == S_RD) r_rdata <= PSG_DO;

            r_bdir <= w_bdir_nxt;
            r_bc   <= w_bc_nxt;
            r_cs   <= w_cs_nxt;
            r_di   <= w_di_nxt;
        end
    end

endmodule

// File: tb/tb_ym_bus_sched.sv
// tb/tb_ym_bus_sched.sv - directed scoreboard bench for ym_bus_sched with a behavioural PSG
module tb_ym_bus_sched;

    localparam byte G_CPU = 8'h43;
    localparam byte G_PLY = 8'h50;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_req, cpu_we, cpu_ack;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_wdata, cpu_rdata;
    logic       ply_valid, ply_ready;
    logic [3:0] ply_addr;
    logic [7:0] ply_data;
    logic       psg_rst, bdir, bc, cs, busy;
    logic [7:0] di, psg_do;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ym_bus_sched #(.STB_CYC(2)) dut (
        .CLK(clk), .RESET_N(rst_n),
        .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata),
        .CPU_ACK(cpu_ack), .CPU_RDATA(cpu_rdata),
        .PLY_VALID(ply_valid), .PLY_ADDR(ply_addr), .PLY_DATA(ply_data), .PLY_READY(ply_ready),
        .PSG_RST(psg_rst), .PSG_BDIR(bdir), .PSG_BC(bc), .PSG_CS(cs), .PSG_DI(di),
        .PSG_DO(psg_do), .BUSY(busy)
    );

    // Behavioural PSG: latches address or data on the BDIR rising edge, masks read-back.
    logic [7:0] ymreg [16];
    logic [3:0] ym_addr;
    logic       ym_prev_bdir = 1'b0;

    function automatic logic [7:0] ym_mask(input logic [3:0] a);
        case (a)
            4'd1, 4'd3, 4'd5, 4'd13: return 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10: return 8'h1F;
            default:                 return 8'hFF;
        endcase
    endfunction

    assign psg_do = ymreg[ym_addr] & ym_mask(ym_addr);

    always @(negedge clk) begin
        if (psg_rst) begin
            ym_addr <= 4'd0;
            for (int i = 0; i < 16; i++) ymreg[i] <= 8'd0;
        end else if (bdir && !ym_prev_bdir && cs) begin
            if (bc) ym_addr <= di[3:0];
            else    ymreg[ym_addr] <= di;
        end
        ym_prev_bdir <= bdir;
    end

    // Bus monitor: logs grants, strobe widths and DI/BC stability violations.
    byte        q_gobs [$];
    byte        q_gexp [$];
    int         q_lat  [$];
    logic [7:0] q_rd   [$];
    int         m_cpu_gnt_cyc = 0;
    int         m_rdy_cnt = 0;
    int         m_pcnt = 0;
    int         m_curw = 0;
    int         m_di_bad = 0;
    int         m_bc_bad = 0;
    int         p_w  [256];
    logic       p_bc [256];
    logic       m_prev_bdir = 1'b0;
    logic       m_prev_bc = 1'b0;
    logic [7:0] m_prev_di = 8'd0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (!busy && ply_ready) begin
                q_gobs.push_back(G_PLY);
            end else if (!busy && cpu_req && !cpu_ack) begin
                q_gobs.push_back(G_CPU);
                m_cpu_gnt_cyc <= cyc;
            end
            if (ply_ready) m_rdy_cnt <= m_rdy_cnt + 1;
            if (bdir && !m_prev_bdir) begin
                if (di !== m_prev_di) m_di_bad <= m_di_bad + 1;
                p_bc[m_pcnt & 255] <= bc;
                m_curw <= 1;
            end else if (bdir) begin
                m_curw <= m_curw + 1;
            end else if (m_prev_bdir) begin
                if (di !== m_prev_di) m_di_bad <= m_di_bad + 1;
                p_w[m_pcnt & 255] <= m_curw;
                m_pcnt <= m_pcnt + 1;
            end
            if ((bc !== m_prev_bc) && (bdir || m_prev_bdir)) m_bc_bad <= m_bc_bad + 1;
        end
        m_prev_bdir <= bdir;
        m_prev_bc   <= bc;
        m_prev_di   <= di;
    end

    logic [7:0] exp_reg [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One CPU access; expected latency/read data go on the scoreboard before driving.
    task automatic cpu_op(input logic we, input logic [3:0] a, input logic [7:0] d,
                          input int exp_lat, input logic [7:0] exp_rd, input string tag,
                          input bit track);
        bit got;
        int lat, el;
        logic [7:0] er;
        q_lat.push_back(exp_lat);
        q_rd.push_back(exp_rd);
        if (track) q_gexp.push_back(G_CPU);
        if (we) exp_reg[a] = d;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (cpu_ack) got = 1'b1;
        end
        lat = cyc - m_cpu_gnt_cyc;
        el  = q_lat.pop_front();
        er  = q_rd.pop_front();
        if (!got) begin
            chk({tag, "_ack_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_latency"}, lat, el);
            if (!we) chk({tag, "_rdata"}, cpu_rdata, er);
        end
        #1 cpu_req = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int  p0, r0;
        bit  ok, ack_seen;
        rst_n = 1'b0; psg_rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 4'd0; cpu_wdata = 8'd0;
        ply_valid = 1'b0; ply_addr = 4'd0; ply_data = 8'd0;
        for (int i = 0; i < 16; i++) exp_reg[i] = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_bdir", bdir, 0);
        chk("rst_bc", bc, 0);
        chk("rst_cs", cs, 0);
        chk("rst_di", di, 0);
        chk("rst_ack", cpu_ack, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_ply_ready", ply_ready, 0);
        #1 rst_n = 1'b1; psg_rst = 1'b0;

        // Write miss: address strobe then data strobe, 9 cycles.
        p0 = m_pcnt;
        cpu_op(1'b1, 4'd7, 8'h3E, 9, 8'h00, "wr_miss", 1);
        chk("wr_miss_pulses", m_pcnt - p0, 2);
        chk("wr_miss_w0", p_w[p0 & 255], 2);
        chk("wr_miss_w1", p_w[(p0 + 1) & 255], 2);
        chk("wr_miss_bc0", p_bc[p0 & 255], 1);
        chk("wr_miss_bc1", p_bc[(p0 + 1) & 255], 0);
        chk("wr_miss_reg7", ymreg[7], 8'h3E);

        // Write hit: data strobe only, 5 cycles.
        p0 = m_pcnt;
        cpu_op(1'b1, 4'd7, 8'h38, 5, 8'h00, "wr_hit", 1);
        chk("wr_hit_pulses", m_pcnt - p0, 1);
        chk("wr_hit_w0", p_w[p0 & 255], 2);
        chk("wr_hit_bc0", p_bc[p0 & 255], 0);
        chk("wr_hit_reg7", ymreg[7], 8'h38);

        // Contention after reset: CPU wins first tie, then strict alternation.
        pulse_reset();
        for (int i = 0; i < 14; i++) begin
            q_gexp.push_back(G_CPU);
            q_gexp.push_back(G_PLY);
        end
        r0 = m_rdy_cnt;
        fork
            begin
                for (int i = 0; i < 14; i++)
                    cpu_op(1'b1, (i % 2 == 1) ? 4'd15 : 4'd14, 8'h80 + 8'(i), 9, 8'h00, "cont_cpu", 0);
            end
            begin
                bit pok;
                for (int i = 0; i < 14; i++) begin
                    @(posedge clk); #1;
                    ply_valid = 1'b1; ply_addr = 4'(i); ply_data = 8'hA0 ^ 8'(i * 7);
                    exp_reg[i] = 8'hA0 ^ 8'(i * 7);
                    pok = 1'b0;
                    for (int k = 0; k < 300 && !pok; k++) begin
                        @(negedge clk);
                        if (ply_ready) pok = 1'b1;
                    end
                    if (!pok) chk("ply_accept_timeout", 32'd0, 32'd1);
                end
                @(posedge clk); #1 ply_valid = 1'b0;
            end
        join
        repeat (12) @(negedge clk);
        chk("cont_ready_cycles", m_rdy_cnt - r0, 14);
        for (int i = 0; i < 16; i++) chk($sformatf("cont_reg%0d", i), ymreg[i], exp_reg[i]);

        // Read hit after writing the same register.
        cpu_op(1'b1, 4'd1, 8'hA5, 9, 8'h00, "rd_prep", 1);
        cpu_op(1'b0, 4'd1, 8'h00, 2, 8'h05, "rd_hit", 1);

        // PSG reset invalidates the cache: a repeated address misses.
        cpu_op(1'b1, 4'd0, 8'h77, 9, 8'h00, "psgrst_prep", 1);
        @(posedge clk); #1 psg_rst = 1'b1;
        @(posedge clk); #1 psg_rst = 1'b0;
        for (int i = 0; i < 16; i++) exp_reg[i] = 8'd0;
        cpu_op(1'b1, 4'd0, 8'h12, 9, 8'h00, "psgrst_wr", 1);
        chk("psgrst_reg0", ymreg[0], 8'h12);

        // Async reset during the data strobe of a hit write.
        q_gexp.push_back(G_CPU);
        exp_reg[0] = 8'h44;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd0; cpu_wdata = 8'h44;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (bdir && !bc) ok = 1'b1;
        end
        chk("arst_reach_dst", ok, 1);
        #1 rst_n = 1'b0; cpu_req = 1'b0;
        #1;
        chk("arst_bdir", bdir, 0);
        chk("arst_cs", cs, 0);
        chk("arst_busy", busy, 0);
        ack_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ack) ack_seen = 1'b1;
        end
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ack) ack_seen = 1'b1;
        end
        chk("arst_no_ack", ack_seen, 0);
        cpu_op(1'b1, 4'd0, 8'h55, 9, 8'h00, "arst_next_miss", 1);

        // Grant order scoreboard, bus-timing invariants and final register image.
        chk("grant_count", q_gobs.size(), q_gexp.size());
        while (q_gobs.size() > 0 && q_gexp.size() > 0)
            chk($sformatf("grant_%0d", n_tests), q_gobs.pop_front(), q_gexp.pop_front());
        chk("di_stability", m_di_bad, 0);
        chk("bc_stability", m_bc_bad, 0);
        for (int i = 0; i < 16; i++) chk($sformatf("final_reg%0d", i), ymreg[i], exp_reg[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
